// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic inter-stage pipeline register with 2-entry skid buffer
// Optional feature macro: PIPE_STAGE_PERF_EN (adds stall/flush performance counters)
module pipe_stage_reg #(
    parameter int          DATA_W    = 32,
    parameter int          PC_W      = 32,
    parameter [DATA_W-1:0] NOP_INSTR = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc4,
    input  logic              flush,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic [1:0]        occupancy
);

    // Encoding equals the number of held entries, so occupancy is the state flop itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]   main_pc4_q, main_pc4_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]   skid_pc4_q, skid_pc4_d;
    logic              in_fire;
    logic              out_fire;

    // Next-state and datapath selection; flush overrides every transition.
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc4_d   = main_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        in_fire      = in_valid & in_ready_q;
        out_fire     = out_valid_q & out_ready;

        if (flush) begin
            // An entry accepted this cycle is squashed along with the held ones.
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
            main_pc4_d   = '0;
            skid_instr_d = NOP_INSTR;
            skid_pc4_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        main_instr_d = in_instr;
                        main_pc4_d   = in_pc4;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_instr_d = in_instr;
                        main_pc4_d   = in_pc4;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new entry behind the head.
                        state_d      = ST_FULL;
                        skid_instr_d = in_instr;
                        skid_pc4_d   = in_pc4;
                    end else if (out_fire) begin
                        state_d      = ST_EMPTY;
                        main_instr_d = NOP_INSTR;
                        main_pc4_d   = '0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d      = ST_ONE;
                        main_instr_d = skid_instr_q;
                        main_pc4_d   = skid_pc4_q;
                        skid_instr_d = NOP_INSTR;
                        skid_pc4_d   = '0;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_instr_d = NOP_INSTR;
                    main_pc4_d   = '0;
                    skid_instr_d = NOP_INSTR;
                    skid_pc4_d   = '0;
                end
            endcase
        end

        // Handshake outputs are registered from the next state to keep them flop-driven.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State and storage registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_instr_q <= NOP_INSTR;
            main_pc4_q   <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            main_instr_q <= main_instr_d;
            main_pc4_q   <= main_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = main_instr_q;
    assign out_pc4   = main_pc4_q;
    assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    // Counters wrap naturally; a flush cycle is never counted as a stall.
    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (out_valid_q && !out_ready && !flush) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
        if (flush && (state_q != ST_EMPTY)) begin
            perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        flush;
    logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(32), .PC_W(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .flush     (flush),
`ifdef PIPE_STAGE_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .occupancy (occupancy)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] occ, input logic rdy,
                               input logic vld, input logic [31:0] ins, input logic [31:0] pc);
        check({tag, ".occupancy"}, {62'd0, occupancy}, {62'd0, occ});
        check({tag, ".in_ready"},  {63'd0, in_ready},  {63'd0, rdy});
        check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, vld});
        check({tag, ".out_instr"}, {32'd0, out_instr}, {32'd0, ins});
        check({tag, ".out_pc4"},   {32'd0, out_pc4},   {32'd0, pc});
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc4    = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        #1;
        check_state("reset", 2'd0, 1'b1, 1'b0, NOP, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
        check("reset.stall_cnt", {32'd0, perf_stall_cnt}, 64'd0);
        check("reset.flush_cnt", {32'd0, perf_flush_cnt}, 64'd0);
`endif
        step();
        reset = 1'b0;

        // First transfer: one-cycle latency.
        in_valid = 1'b1;
        in_instr = 32'h00A0_0093;
        in_pc4   = 32'h4;
        step();
        check_state("first", 2'd1, 1'b1, 1'b1, 32'h00A0_0093, 32'h4);

        // Back-to-back stream of 8 entries; each appears the cycle after it is offered.
        for (int i = 0; i < 8; i++) begin
            in_instr = 32'h0000_1000 + 32'(i);
            in_pc4   = 32'h100 + 32'(4 * i);
            step();
            check_state($sformatf("stream%0d", i), 2'd1, 1'b1, 1'b1,
                        32'h0000_1000 + 32'(i), 32'h100 + 32'(4 * i));
        end
        in_valid = 1'b0;
        step();
        check_state("drain", 2'd0, 1'b1, 1'b0, NOP, 32'h0);

        // Back-pressure: skid absorbs one, then the stage freezes.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hAAAA_0001;
        in_pc4    = 32'h200;
        step();
        check_state("stallA", 2'd1, 1'b1, 1'b1, 32'hAAAA_0001, 32'h200);
        in_instr = 32'hBBBB_0002;
        in_pc4   = 32'h204;
        step();
        check_state("stallB", 2'd2, 1'b0, 1'b1, 32'hAAAA_0001, 32'h200);
        in_instr = 32'hCCCC_0003;
        in_pc4   = 32'h208;
        step();
        check_state("frozen", 2'd2, 1'b0, 1'b1, 32'hAAAA_0001, 32'h200);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_state("unstallB", 2'd1, 1'b1, 1'b1, 32'hBBBB_0002, 32'h204);
        step();
        check_state("unstallE", 2'd0, 1'b1, 1'b0, NOP, 32'h0);

        // Flush while FULL with upstream still offering.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h1111_0001;
        in_pc4    = 32'h300;
        step();
        in_instr = 32'h2222_0002;
        in_pc4   = 32'h304;
        step();
        check_state("preflush", 2'd2, 1'b0, 1'b1, 32'h1111_0001, 32'h300);
        flush    = 1'b1;
        in_instr = 32'h3333_0003;
        in_pc4   = 32'h308;
        step();
        check_state("flushFull", 2'd0, 1'b1, 1'b0, NOP, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
        check("flushFull.flush_cnt", {32'd0, perf_flush_cnt}, 64'd1);
`endif

        // Flush in ONE with a genuine in_fire: the accepted entry is discarded.
        flush = 1'b0;
        step();
        check_state("preflush1", 2'd1, 1'b1, 1'b1, 32'h3333_0003, 32'h308);
        flush    = 1'b1;
        in_instr = 32'h4444_0004;
        step();
        check_state("flushOne", 2'd0, 1'b1, 1'b0, NOP, 32'h0);
        flush    = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset mid-cycle while FULL.
        in_valid = 1'b1;
        in_instr = 32'h5555_0001;
        in_pc4   = 32'h400;
        step();
        in_instr = 32'h6666_0002;
        step();
        in_valid = 1'b0;
        check_state("prereset", 2'd2, 1'b0, 1'b1, 32'h5555_0001, 32'h400);
        #2;
        reset = 1'b1;
        #1;
        check_state("asyncReset", 2'd0, 1'b1, 1'b0, NOP, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
        check("asyncReset.stall_cnt", {32'd0, perf_stall_cnt}, 64'd0);
        check("asyncReset.flush_cnt", {32'd0, perf_flush_cnt}, 64'd0);
`endif
        #1;
        reset = 1'b0;

        // First accept after reset release, then a 5-cycle stall and a flush.
        in_valid = 1'b1;
        in_instr = 32'h7777_0007;
        in_pc4   = 32'h500;
        step();
        check_state("postReset", 2'd1, 1'b1, 1'b1, 32'h7777_0007, 32'h500);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_state("stall5", 2'd1, 1'b1, 1'b1, 32'h7777_0007, 32'h500);
`ifdef PIPE_STAGE_PERF_EN
        check("stall5.stall_cnt", {32'd0, perf_stall_cnt}, 64'd5);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_state("flushAfterStall", 2'd0, 1'b1, 1'b0, NOP, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
        check("flushAfterStall.stall_cnt", {32'd0, perf_stall_cnt}, 64'd5);
        check("flushAfterStall.flush_cnt", {32'd0, perf_flush_cnt}, 64'd1);
`endif
        out_ready = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic inter-stage pipeline register, the successor of the fixed IF/ID latch. It carries an instruction word and its PC+4 between any two pipeline stages using a valid/ready handshake with a 2-entry skid buffer, so back-pressure never creates a combinational ready path. Flush inserts a NOP bubble. One instance sits at each stage boundary (IF/ID, ID/EX, …).

## Interface
Parameters:
- DATA_W, 32, instruction/payload width
- PC_W, 32, PC+4 width
- NOP_INSTR, {DATA_W{1'b0}}, value driven on out_instr when the stage holds no valid entry

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; registered, = (state != FULL)
- in_instr  in  DATA_W  upstream instruction
- in_pc4  in  PC_W  upstream PC+4
- out_valid  out  1  registered, = (state != EMPTY)
- out_ready  in  1  downstream accepts; low = stall
- out_instr  out  DATA_W  head entry instruction, NOP_INSTR when empty
- out_pc4  out  PC_W  head entry PC+4, 0 when empty
- flush  in  1  synchronous squash of all held entries
- occupancy  out  2  entries held, 0..2

## Operation
- Fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (head, drives out_*) and skid register.
- States: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid).
- EMPTY: in_fire -> ONE, main <= in.
- ONE: in_fire & out_fire -> ONE, main <= in; in_fire only -> FULL, skid <= in; out_fire only -> EMPTY, main <= {NOP_INSTR, 0}; neither -> hold.
- FULL: in_ready = 0; out_fire -> ONE, main <= skid, skid cleared; else hold.
- Flush: priority over every transition except reset; next state EMPTY, main and skid <= {NOP_INSTR, 0}. An in_fire in the flush cycle counts as accepted upstream and is discarded.
- Reset: state EMPTY, in_ready = 1, out_valid = 0, out_instr = NOP_INSTR, out_pc4 = 0, occupancy = 0, skid cleared.
- Order preserved; no entry duplicated or dropped except by flush.
- out_* stable while out_valid & !out_ready (no flush).

## Timing
- Latency: 1 cycle from in_fire to out_valid with that entry.
- Throughput: 1 entry/cycle sustained while out_ready = 1.
- in_ready, out_valid, out_*, occupancy: pure flop outputs, no combinational path from any input.
- out_ready drop: stage absorbs at most one extra entry (skid); in_ready falls on the next edge.
- Reset asserted mid-transfer: immediate clear regardless of clk; first in_fire possible the first edge after deassertion.

## Configuration
- PIPE_STAGE_PERF_EN defined: adds outputs perf_stall_cnt [31:0] (increments each cycle out_valid & !out_ready & !flush) and perf_flush_cnt [31:0] (increments each cycle flush = 1 with occupancy != 0). Both reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour identical.

## Test plan
- Reset then in_valid = 1, instr 0x00A00093, pc4 0x4, out_ready = 1 -> next cycle out_valid = 1, out_instr = 0x00A00093, out_pc4 = 0x4, occupancy = 1.
- Stream 8 entries back-to-back with out_ready = 1 -> 8 consecutive out_fires, in order, 1-cycle latency, in_ready never low.
- out_ready = 0 while streaming -> occupancy reaches 2, in_ready = 0 next cycle, out_* frozen; out_ready = 1 -> both entries drain in order, no loss or duplication.
- Flush in FULL with simultaneous in_fire -> next cycle occupancy = 0, out_valid = 0, out_instr = NOP_INSTR, out_pc4 = 0, in_ready = 1; with PIPE_STAGE_PERF_EN, perf_flush_cnt += 1.
- Assert reset asynchronously between edges while FULL -> outputs return to reset values immediately.
- With PIPE_STAGE_PERF_EN, hold out_ready = 0 for 5 cycles with out_valid = 1 -> perf_stall_cnt = 5.
